// File: rtl/ic74161_counter_pkg.sv
// Shared widths and default 74xx delays for the 74161 counter model.
`timescale 1ns/1ps
package ic74161_counter_pkg;

  localparam int unsigned CNT_W     = 4;

  // Board-level propagation delays in ns; consumed by testbenches for sample points.
  localparam int unsigned TPD_CLK_Q = 20;
  localparam int unsigned TPD_CLR_Q = 20;
  localparam int unsigned TPD_RCO   = 15;

  function automatic logic all_ones(input logic [CNT_W-1:0] v);
    return &v;
  endfunction

endpackage

// File: rtl/ic74161_bit.sv
// One counter stage: async-clear flop with synchronous load and toggle.
`timescale 1ns/1ps
module ic74161_bit (
  input  logic clk,
  input  logic ncl,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);

  logic nxt;

  // Ternary keeps an unknown load select visible as X on q.
  always_comb begin
    nxt = ld ? d : (q ^ t);
  end

  always_ff @(posedge clk or negedge ncl) begin
    if (!ncl) begin
      q <= 1'b0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/ic74161_counter.sv
// 74161 synchronous 4-bit binary counter: async clear, sync load, dual enables, rco.
`timescale 1ns/1ps
module ic74161_counter
  import ic74161_counter_pkg::*;
(
  input  logic             clk,
  input  logic             ncl,
  input  logic             nld,
  input  logic             enp,
  input  logic             ent,
  input  logic [CNT_W-1:0] d,
  output logic [CNT_W-1:0] q,
  output logic             rco
);

  logic             ld;
  logic [CNT_W-1:0] tgl;

  // Bit i toggles when both enables are high and every lower bit is 1.
  always_comb begin
    logic run;
    ld  = ~nld;
    tgl = '0;
    run = enp & ent;
    for (int i = 0; i < int'(CNT_W); i++) begin
      tgl[i] = run;
      run    = run & q[i];
    end
  end

  for (genvar i = 0; i < int'(CNT_W); i++) begin : g_bit
    ic74161_bit u_bit (
      .clk (clk),
      .ncl (ncl),
      .ld  (ld),
      .d   (d[i]),
      .t   (tgl[i]),
      .q   (q[i])
    );
  end

  // Ripple carry is combinational so cascaded stages see it before the next edge.
  assign rco = ent & all_ones(q);

endmodule
